// File: rtl/mips_pkg.sv
// Shared definitions for the instruction entry path: word width, chunk
// defaults and the loader state encoding.
package mips_pkg;

    localparam int INSTR_W        = 32;
    localparam int CHUNK_W_DEF    = 6;
    localparam int NUM_CHUNKS_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } loader_state_e;

    // The loader is busy whenever it is not waiting for the first chunk.
    function automatic logic state_busy(input loader_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Switch debouncer: the filtered level follows the raw input only after
// CYCLES consecutive samples that differ from the current filtered level.
// The raw input is sampled directly; callers that need metastability
// hardening should synchronise it first.
module input_debouncer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Count consecutive disagreeing samples and flip the level on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (raw != level_r) begin
            if (cnt_r == CNT_W'(CYCLES - 1)) begin
                level_r <= raw;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign level = level_r;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: assembles a 32-bit instruction from switch chunks,
// one chunk per rising edge of read, then offers it with valid/ready.
// Build option: INSTR_LOADER_DEBOUNCE_EN routes read through input_debouncer.
module instr_loader
    import mips_pkg::*;
#(
    parameter int CHUNK_W         = CHUNK_W_DEF,
    parameter int NUM_CHUNKS      = NUM_CHUNKS_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHUNK_W-1:0]   sw_data,
    input  logic                 read,
    input  logic                 pause,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instruction,
    output logic                 instr_valid,
    output logic [2:0]           chunk_count,
    output logic                 busy,
    output logic                 overrun
);

    localparam int ASM_W = CHUNK_W * NUM_CHUNKS;

    logic                 read_lvl_s;
    logic                 read_q_r;
    logic                 read_rise_s;

    loader_state_e        state_r, state_n;
    logic [ASM_W-1:0]     asm_r, asm_n;
    logic [ASM_W-1:0]     shifted_s;
    logic [INSTR_W-1:0]   instr_r, instr_n;
    logic                 valid_r, valid_n;
    logic [2:0]           cnt_r, cnt_n;
    logic [2:0]           cnt_inc_s;
    logic                 busy_r, busy_n;
    logic                 overrun_r, overrun_n;

`ifdef INSTR_LOADER_DEBOUNCE_EN
    input_debouncer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_read_debouncer (
        .clk   (clk),
        .reset (reset),
        .raw   (read),
        .level (read_lvl_s)
    );

    // Bits above the instruction word only carry the discarded chunk MSBs.
    logic unused_asm_s;
    assign unused_asm_s = ^asm_r[ASM_W-1:INSTR_W];
`else
    assign read_lvl_s = read;

    // Bits above the instruction word only carry the discarded chunk MSBs;
    // the debounce length has no meaning without the debouncer.
    logic unused_asm_s;
    assign unused_asm_s = ^{asm_r[ASM_W-1:INSTR_W], 32'(DEBOUNCE_CYCLES)};
`endif

    // Previous read level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q_r <= 1'b0;
        end else begin
            read_q_r <= read_lvl_s;
        end
    end

    // Edges seen while paused are dropped for good, never replayed.
    assign read_rise_s = read_lvl_s & ~read_q_r & ~pause;
    assign shifted_s   = {asm_r[ASM_W-CHUNK_W-1:0], sw_data};
    assign cnt_inc_s   = cnt_r + 3'd1;

    // Next-state logic for the entry FSM, assembly register and status.
    always_comb begin
        state_n   = state_r;
        asm_n     = asm_r;
        instr_n   = instr_r;
        valid_n   = valid_r;
        cnt_n     = cnt_r;
        overrun_n = overrun_r;
        case (state_r)
            ST_IDLE: begin
                if (read_rise_s) begin
                    asm_n   = shifted_s;
                    cnt_n   = 3'd1;
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (read_rise_s) begin
                    asm_n = shifted_s;
                    cnt_n = cnt_inc_s;
                    if (cnt_inc_s == 3'(NUM_CHUNKS)) begin
                        state_n = ST_HOLD;
                        valid_n = 1'b1;
                        instr_n = shifted_s[INSTR_W-1:0];
                    end else begin
                        state_n = ST_COLLECT;
                    end
                end else begin
                    state_n = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                // A chunk arriving while a word is held is never committed.
                if (read_rise_s) begin
                    overrun_n = 1'b1;
                end else begin
                    overrun_n = overrun_r;
                end
                if (valid_r && instr_ready) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    cnt_n   = 3'd0;
                    asm_n   = {ASM_W{1'b0}};
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                cnt_n   = 3'd0;
                asm_n   = {ASM_W{1'b0}};
            end
        endcase
        busy_n = state_busy(state_n);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            asm_r     <= {ASM_W{1'b0}};
            instr_r   <= {INSTR_W{1'b0}};
            valid_r   <= 1'b0;
            cnt_r     <= 3'd0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            asm_r     <= asm_n;
            instr_r   <= instr_n;
            valid_r   <= valid_n;
            cnt_r     <= cnt_n;
            busy_r    <= busy_n;
            overrun_r <= overrun_n;
        end
    end

    assign instruction = instr_r;
    assign instr_valid = valid_r;
    assign chunk_count = cnt_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with a scoreboard of expected words.
module tb_instr_loader;

`ifdef INSTR_LOADER_DEBOUNCE_EN
    localparam int LAT = 4 + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  sw_data;
    logic        read;
    logic        pause;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [2:0]  chunk_count;
    logic        busy;
    logic        overrun;

    int          checks = 0;
    int          fails  = 0;
    int          hs_count = 0;
    logic [31:0] sb_q[$];
    logic [35:0] m_asm = 36'd0;
    int          m_cnt = 0;

    instr_loader #(
        .CHUNK_W         (6),
        .NUM_CHUNKS      (6),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_data     (sw_data),
        .read        (read),
        .pause       (pause),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .chunk_count (chunk_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Count completed handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) hs_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one committed chunk; queues the word when the sixth lands.
    task automatic commit(input logic [5:0] v);
        m_asm = {m_asm[29:0], v};
        m_cnt++;
        if (m_cnt == 6) sb_q.push_back(m_asm[31:0]);
    endtask

    task automatic press(input logic [5:0] v);
        sw_data = v;
        read = 1'b1;
        repeat (LAT) tick();
    endtask

    task automatic release_read();
        read = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic enter(input logic [5:0] v);
        press(v);
        commit(v);
        release_read();
    endtask

    task automatic accept();
        int          hs_before;
        logic [31:0] exp;
        hs_before = hs_count;
        check("acc_valid_before", {31'd0, instr_valid}, 32'd1);
        check("sb_nonempty", {31'd0, (sb_q.size() > 0)}, 32'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check("acc_instruction", instruction, exp);
        instr_ready = 1'b1;
        tick();
        check("acc_valid_after", {31'd0, instr_valid}, 32'd0);
        check("acc_count_after", {29'd0, chunk_count}, 32'd0);
        check("acc_busy_after", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        instr_ready = 1'b0;
        check("acc_once", hs_count - hs_before, 32'd1);
        m_asm = 36'd0;
        m_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; pause = 1'b0; instr_ready = 1'b0; sw_data = 6'd0;
        repeat (3) tick();
        check("rst_instruction", instruction, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_count", {29'd0, chunk_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic entry of 0x012A4020.
        enter(6'h00);
        check("t1_count1", {29'd0, chunk_count}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        enter(6'h01);
        enter(6'h0A);
        enter(6'h24);
        enter(6'h00);
        check("t1_count5", {29'd0, chunk_count}, 32'd5);
        check("t1_valid_early", {31'd0, instr_valid}, 32'd0);
        press(6'h20);
        commit(6'h20);
        check("t1_valid", {31'd0, instr_valid}, 32'd1);
        check("t1_instr_const", instruction, 32'h012A4020);
        check("t1_count6", {29'd0, chunk_count}, 32'd6);
        release_read();
        check("t1_hold_stable", instruction, 32'h012A4020);
        accept();

        // Edges during pause are lost.
        pause = 1'b1;
        repeat (3) begin
            press(6'h3F);
            release_read();
        end
        check("t3_count_paused", {29'd0, chunk_count}, 32'd0);
        check("t3_idle_paused", {31'd0, busy}, 32'd0);
        pause = 1'b0;
        tick();
        check("t3_no_replay", {29'd0, chunk_count}, 32'd0);
        enter(6'h05);
        check("t3_count1", {29'd0, chunk_count}, 32'd1);
        enter(6'h11);
        enter(6'h22);
        enter(6'h33);
        enter(6'h04);
        enter(6'h2A);
        check("t3_valid", {31'd0, instr_valid}, 32'd1);

        // Overrun in HOLD, sticky through the next entry.
        check("t4_overrun_pre", {31'd0, overrun}, 32'd0);
        press(6'h15);
        check("t4_overrun_set", {31'd0, overrun}, 32'd1);
        check("t4_instr_kept", instruction, sb_q[0]);
        check("t4_count_kept", {29'd0, chunk_count}, 32'd6);
        release_read();
        accept();
        enter(6'h07);
        check("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
        check("t4_count1", {29'd0, chunk_count}, 32'd1);
        enter(6'h08);
        enter(6'h09);
        check("t4_count3", {29'd0, chunk_count}, 32'd3);

        // Reset mid-entry discards everything.
        reset = 1'b1;
        tick();
        check("t5_rst_instruction", instruction, 32'd0);
        check("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_rst_count", {29'd0, chunk_count}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        m_asm = 36'd0;
        m_cnt = 0;
        tick();
        enter(6'h23);
        repeat (5) enter(6'h3F);
        check("t5_valid", {31'd0, instr_valid}, 32'd1);
        check("t5_instr_const", instruction, 32'hFFFFFFFF);
        accept();

`ifdef INSTR_LOADER_DEBOUNCE_EN
        // Short glitch is filtered; a stable high commits exactly once.
        sw_data = 6'h2B;
        read = 1'b1;
        repeat (2) tick();
        read = 1'b0;
        repeat (8) tick();
        check("db_glitch", {29'd0, chunk_count}, 32'd0);
        read = 1'b1;
        repeat (5) tick();
        commit(6'h2B);
        check("db_commit", {29'd0, chunk_count}, 32'd1);
        repeat (6) tick();
        check("db_once", {29'd0, chunk_count}, 32'd1);
        release_read();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
